spi_ctrl_regfile: RTL

- Parametrised SPI target (mode 0) for the control block, oversampled entirely in the `clk` domain.
- A frame is one command byte followed by one or more data words.
- The block decodes frames into reads and writes of a NUM_REGS x DATA_W configuration register file that drives the rest of the control group.
- Beyond the previous generation it adds configurable word width and depth, burst auto-increment with address wrap, and register read-back on `poci`.

---
 rtl/spi_ctrl_regfile.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_ctrl_regfile.sv
// SPI mode-0 target oversampled in the clk domain, decoding command/data frames
// into reads and writes of a NUM_REGS x DATA_W configuration register file.
module spi_ctrl_regfile #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_clk,
  input  logic                         spi_cs_n,
  input  logic                         pico,
  output logic                         poci,
  output logic                         poci_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [6:0]                   wr_addr
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] pico_sync_q, pico_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [6:0]             cmd_q, cmd_d;
  logic [DATA_W-2:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic [6:0]             addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   poci_q, poci_d;
  logic                   poci_oe_q, poci_oe_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [6:0]             wr_addr_q, wr_addr_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  logic              sclk_s, cs_s, pico_s;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_W-1:0] word;
  logic [6:0]        cmd_addr, nxt_addr;

  function automatic logic in_range(input logic [6:0] a);
    return {25'd0, a} < 32'(NUM_REGS);
  endfunction

  // In-range addresses wrap at the top of the file; others count modulo 128.
  function automatic logic [6:0] next_addr(input logic [6:0] a);
    if (in_range(a) && a == 7'(NUM_REGS - 1)) return 7'd0;
    return a + 7'd1;
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [6:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == 7'(i)) v = regs_q[i];
    return v;
  endfunction

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign pico_s    = pico_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_hist_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign word      = {rx_q, pico_s};
  assign cmd_addr  = {cmd_q[5:0], pico_s};
  assign nxt_addr  = next_addr(addr_q);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    pico_sync_d = {pico_sync_q[SYNC_STAGES-2:0], pico};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;

    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    poci_d      = poci_q;
    poci_oe_d   = ~cs_s;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;

    // A CS rise aborts whatever is in flight, including a word completing this cycle.
    if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      poci_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          poci_d = 1'b0;
          if (cs_fall) state_d = CMD;
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d = {cmd_q[5:0], pico_s};
            if (cnt_q == CNT_W'(7)) begin
              rw_d    = cmd_q[6];
              addr_d  = cmd_addr;
              cnt_d   = '0;
              state_d = DATA;
              if (cmd_q[6]) tx_d = in_range(cmd_addr) ? read_reg(cmd_addr) : '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_d = word[DATA_W-2:0];
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d  = '0;
              addr_d = nxt_addr;
              if (rw_q) begin
                tx_d = in_range(nxt_addr) ? read_reg(nxt_addr) : '0;
              end else if (in_range(addr_q)) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (addr_q == 7'(i)) regs_d[i] = word;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall && rw_q) begin
            poci_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      pico_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      poci_q      <= 1'b0;
      poci_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      regs_q      <= {NUM_REGS{RST_VAL}};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      pico_sync_q <= pico_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      poci_q      <= poci_d;
      poci_oe_q   <= poci_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  assign poci      = poci_q;
  assign poci_oe   = poci_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign regs_flat = regs_q;

endmodule
